// File: rtl/mem_wb_stage.sv
// mem_wb_stage: memory access stage with an internal big-endian data memory,
// combinational branch resolution towards IF, and the MEM/WB pipeline register.
//
// Ports:
//   CLK, RST_N                 clock, synchronous active-low reset
//   EX_MEM_*                   EX/MEM pipeline register contents (control, address,
//                              store data, branch target, destination)
//   MEM_IF_BR_NEXT_INS_ADR     branch target to IF (combinational)
//   MEM_IF_MEM_WRITE           take-branch select to IF (combinational)
//   delay_write_register       WB destination register
//   delay_write_data           WB data (load data or ALU result)
//   delay_in_RegWrite          WB enable
//   delay_in_load_mode         WB access size, pass-through
//   MISALIGN                   sticky misaligned-access flag, cleared only by reset
module mem_wb_stage #(
  parameter int unsigned DEPTH = 256
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        EX_MEM_zero_out,
  input  logic        EX_MEM_branch_out,
  input  logic        EX_MEM_RegWrite_out,
  input  logic        EX_MEM_MemWrite_out,
  input  logic        EX_MEM_MemRead_out,
  input  logic        EX_MEM_MemToReg_out,
  input  logic [1:0]  EX_MEM_load_mode_out,
  input  logic [4:0]  EX_MEM_IF_MEM_writebackDestination_out,
  input  logic [31:0] EX_MEM_aluResult_out,
  input  logic [31:0] EX_MEM_rt_out,
  input  logic [31:0] EX_MEM_pc_out,
  output logic [31:0] MEM_IF_BR_NEXT_INS_ADR,
  output logic        MEM_IF_MEM_WRITE,
  output logic [4:0]  delay_write_register,
  output logic [31:0] delay_write_data,
  output logic        delay_in_RegWrite,
  output logic [1:0]  delay_in_load_mode,
  output logic        MISALIGN
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] idx;
  logic [1:0]    off;
  logic [31:0]   rd_word;
  logic [7:0]    sel_byte;
  logic [15:0]   sel_half;
  logic [31:0]   ld_data;
  logic [31:0]   wr_word;
  logic          fmt_misaligned;
  logic          access;
  logic          mis_access;
  logic          store_en;
  logic          reg_write_next;
  logic          unused_addr_bits;

  // Word index wraps: address bits above the array size are ignored.
  assign idx = EX_MEM_aluResult_out[AW+1:2];
  assign off = EX_MEM_aluResult_out[1:0];
  assign unused_addr_bits = ^EX_MEM_aluResult_out[31:AW+2];

  // Branch resolution towards IF, forced quiet while in reset.
  assign MEM_IF_MEM_WRITE       = RST_N & EX_MEM_branch_out & EX_MEM_zero_out;
  assign MEM_IF_BR_NEXT_INS_ADR = RST_N ? EX_MEM_pc_out : 32'h0;

  // Alignment: words need addr[1:0]==0, halfwords addr[0]==0, bytes always fine.
  assign fmt_misaligned = ((EX_MEM_load_mode_out == 2'b00) && (off != 2'b00)) ||
                          ((EX_MEM_load_mode_out == 2'b01) && off[0]);
  assign access         = EX_MEM_MemRead_out | EX_MEM_MemWrite_out;
  assign mis_access     = access & fmt_misaligned;
  assign store_en       = EX_MEM_MemWrite_out & ~fmt_misaligned;
  // Load+store in one cycle never writes back; misaligned loads never write back.
  assign reg_write_next = EX_MEM_RegWrite_out
                          & ~(EX_MEM_MemRead_out & fmt_misaligned)
                          & ~(EX_MEM_MemRead_out & EX_MEM_MemWrite_out);

  // Big-endian lane select, load extension and read-modify-write store merge.
  always_comb begin
    rd_word  = mem[idx];
    sel_byte = 8'h0;
    sel_half = off[1] ? rd_word[15:0] : rd_word[31:16];
    ld_data  = rd_word;
    wr_word  = rd_word;

    case (off)
      2'd0:    sel_byte = rd_word[31:24];
      2'd1:    sel_byte = rd_word[23:16];
      2'd2:    sel_byte = rd_word[15:8];
      default: sel_byte = rd_word[7:0];
    endcase

    case (EX_MEM_load_mode_out)
      2'b00:   ld_data = rd_word;
      2'b01:   ld_data = {{16{sel_half[15]}}, sel_half};
      2'b10:   ld_data = {{24{sel_byte[7]}}, sel_byte};
      default: ld_data = {24'h0, sel_byte};
    endcase

    case (EX_MEM_load_mode_out)
      2'b00: wr_word = EX_MEM_rt_out;
      2'b01: begin
        if (off[1]) wr_word[15:0]  = EX_MEM_rt_out[15:0];
        else        wr_word[31:16] = EX_MEM_rt_out[15:0];
      end
      default: begin
        case (off)
          2'd0:    wr_word[31:24] = EX_MEM_rt_out[7:0];
          2'd1:    wr_word[23:16] = EX_MEM_rt_out[7:0];
          2'd2:    wr_word[15:8]  = EX_MEM_rt_out[7:0];
          default: wr_word[7:0]   = EX_MEM_rt_out[7:0];
        endcase
      end
    endcase
  end

  // Memory array, MEM/WB register and sticky flag; reset wins over any store.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= 32'h0;
      delay_write_register <= 5'h0;
      delay_write_data     <= 32'h0;
      delay_in_RegWrite    <= 1'b0;
      delay_in_load_mode   <= 2'b00;
      MISALIGN             <= 1'b0;
    end else begin
      if (store_en) mem[idx] <= wr_word;
      delay_write_register <= EX_MEM_IF_MEM_writebackDestination_out;
      delay_write_data     <= EX_MEM_MemToReg_out ? ld_data : EX_MEM_aluResult_out;
      delay_in_RegWrite    <= reg_write_next;
      delay_in_load_mode   <= EX_MEM_load_mode_out;
      if (mis_access) MISALIGN <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Testbench for mem_wb_stage: directed vector table, hand sequences for
// sticky flag / branch / reset, then random traffic against a reference model.
module tb_mem_wb_stage;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        zero, branch, reg_write, mem_write, mem_read, mem_to_reg;
  logic [1:0]  load_mode;
  logic [4:0]  dest;
  logic [31:0] alu, rt, pc;
  logic [31:0] br_adr;
  logic        br_take;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;
  logic        wb_we;
  logic [1:0]  wb_mode;
  logic        misalign;

  always #5 CLK = ~CLK;

  mem_wb_stage #(.DEPTH(256)) dut (
    .CLK                                    (CLK),
    .RST_N                                  (RST_N),
    .EX_MEM_zero_out                        (zero),
    .EX_MEM_branch_out                      (branch),
    .EX_MEM_RegWrite_out                    (reg_write),
    .EX_MEM_MemWrite_out                    (mem_write),
    .EX_MEM_MemRead_out                     (mem_read),
    .EX_MEM_MemToReg_out                    (mem_to_reg),
    .EX_MEM_load_mode_out                   (load_mode),
    .EX_MEM_IF_MEM_writebackDestination_out (dest),
    .EX_MEM_aluResult_out                   (alu),
    .EX_MEM_rt_out                          (rt),
    .EX_MEM_pc_out                          (pc),
    .MEM_IF_BR_NEXT_INS_ADR                 (br_adr),
    .MEM_IF_MEM_WRITE                       (br_take),
    .delay_write_register                   (wb_reg),
    .delay_write_data                       (wb_data),
    .delay_in_RegWrite                      (wb_we),
    .delay_in_load_mode                     (wb_mode),
    .MISALIGN                               (misalign)
  );

  typedef struct {
    logic        rd, wr, rw, m2r;
    logic [1:0]  mode;
    logic [4:0]  dest;
    logic [31:0] addr, rt;
    logic [31:0] e_data;
    logic        e_rw, e_mis, chk_d;
  } vec_t;

  localparam int unsigned NVEC = 17;
  vec_t tbl [NVEC];

  int n_cmp  = 0;
  int n_fail = 0;

  logic [31:0] mdl [256];
  logic        mdl_mis;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h want 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic rd, input logic wr, input logic rw, input logic m2r,
                              input logic [1:0] mode, input logic [4:0] d,
                              input logic [31:0] addr, input logic [31:0] rtv,
                              input logic [31:0] e_data, input logic e_rw,
                              input logic e_mis, input logic chk_d);
    vec_t v;
    v.rd = rd; v.wr = wr; v.rw = rw; v.m2r = m2r; v.mode = mode; v.dest = d;
    v.addr = addr; v.rt = rtv; v.e_data = e_data; v.e_rw = e_rw; v.e_mis = e_mis;
    v.chk_d = chk_d;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    mem_read = v.rd; mem_write = v.wr; reg_write = v.rw; mem_to_reg = v.m2r;
    load_mode = v.mode; dest = v.dest; alu = v.addr; rt = v.rt;
  endtask

  task automatic idle_inputs();
    zero = 0; branch = 0; reg_write = 0; mem_write = 0; mem_read = 0; mem_to_reg = 0;
    load_mode = 2'b00; dest = 5'd0; alu = 32'h0; rt = 32'h0; pc = 32'h0;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".reg"},  32'(wb_reg),  32'h0);
    chk({tag, ".data"}, wb_data,      32'h0);
    chk({tag, ".we"},   32'(wb_we),   32'h0);
    chk({tag, ".mode"}, 32'(wb_mode), 32'h0);
    chk({tag, ".mis"},  32'(misalign), 32'h0);
  endtask

  // Reference model: byte-granular big-endian memory via shifts and masks.
  function automatic logic m_misal(input logic [31:0] a, input logic [1:0] mode);
    if (mode == 2'd0) return (a % 4) != 0;
    if (mode == 2'd1) return (a % 2) != 0;
    return 1'b0;
  endfunction

  function automatic logic [31:0] m_load(input logic [31:0] w, input logic [31:0] a,
                                         input logic [1:0] mode);
    int unsigned sh_b, sh_h;
    logic [31:0] x;
    sh_b = 8 * (3 - (a % 4));
    sh_h = 16 * (1 - ((a / 2) % 2));
    case (mode)
      2'd0: return w;
      2'd1: begin
        x = (w >> sh_h) & 32'hFFFF;
        return (x >= 32'h8000) ? (x | 32'hFFFF0000) : x;
      end
      2'd2: begin
        x = (w >> sh_b) & 32'hFF;
        return (x >= 32'h80) ? (x | 32'hFFFFFF00) : x;
      end
      default: return (w >> sh_b) & 32'hFF;
    endcase
  endfunction

  function automatic logic [31:0] m_store(input logic [31:0] w, input logic [31:0] a,
                                          input logic [1:0] mode, input logic [31:0] d);
    int unsigned sh;
    logic [31:0] mask;
    if (mode == 2'd0) return d;
    if (mode == 2'd1) begin
      sh = 16 * (1 - ((a / 2) % 2));
      mask = 32'hFFFF << sh;
    end else begin
      sh = 8 * (3 - (a % 4));
      mask = 32'hFF << sh;
    end
    return (w & ~mask) | ((d << sh) & mask);
  endfunction

  initial begin
    vec_t v;
    logic rst, mis;
    logic [31:0] old_w, e_data;
    int unsigned widx;
    string nm;

    // rd wr rw m2r mode dest addr rt | e_data e_rw e_mis chk_d
    tbl[0]  = mk(0,1,0,0, 2'd0, 5'd0, 32'h10,  32'hDEADBEEF, 32'h10,       0, 0, 1);
    tbl[1]  = mk(1,0,1,1, 2'd0, 5'd5, 32'h10,  32'h0,        32'hDEADBEEF, 1, 0, 1);
    tbl[2]  = mk(0,1,0,0, 2'd0, 5'd1, 32'h10,  32'h0,        32'h10,       0, 0, 1);
    tbl[3]  = mk(0,1,0,0, 2'd3, 5'd2, 32'h13,  32'h80,       32'h13,       0, 0, 1);
    tbl[4]  = mk(1,0,1,1, 2'd2, 5'd3, 32'h13,  32'h0,        32'hFFFFFF80, 1, 0, 1);
    tbl[5]  = mk(1,0,1,1, 2'd3, 5'd4, 32'h13,  32'h0,        32'h00000080, 1, 0, 1);
    tbl[6]  = mk(1,0,1,1, 2'd0, 5'd6, 32'h10,  32'h0,        32'h00000080, 1, 0, 1);
    tbl[7]  = mk(0,1,0,0, 2'd1, 5'd7, 32'h22,  32'h1234ABCD, 32'h22,       0, 0, 1);
    tbl[8]  = mk(1,0,1,1, 2'd0, 5'd8, 32'h20,  32'h0,        32'h0000ABCD, 1, 0, 1);
    tbl[9]  = mk(1,0,1,1, 2'd1, 5'd9, 32'h22,  32'h0,        32'hFFFFABCD, 1, 0, 1);
    tbl[10] = mk(0,0,1,0, 2'd0, 5'd0, 32'hCAFEF00D, 32'h0,   32'hCAFEF00D, 1, 0, 1);
    tbl[11] = mk(1,1,1,1, 2'd0, 5'd10, 32'h24, 32'h11112222, 32'h0,        0, 0, 0);
    tbl[12] = mk(1,0,1,1, 2'd0, 5'd11, 32'h24, 32'h0,        32'h11112222, 1, 0, 1);
    tbl[13] = mk(1,0,1,1, 2'd0, 5'd12, 32'h11, 32'h0,        32'h0,        0, 1, 0);
    tbl[14] = mk(0,1,0,0, 2'd0, 5'd13, 32'h12, 32'hFFFFFFFF, 32'h12,       0, 1, 1);
    tbl[15] = mk(1,0,1,1, 2'd0, 5'd14, 32'h10, 32'h0,        32'h00000080, 1, 1, 1);
    tbl[16] = mk(1,0,1,1, 2'd3, 5'd31, 32'h413, 32'h0,       32'h00000080, 1, 1, 1);

    // Reset with branch inputs active: everything must read zero.
    idle_inputs();
    RST_N = 1'b0;
    branch = 1; zero = 1; pc = 32'h40;
    tick();
    tick();
    chk_all_zero("reset");
    chk("reset.br_take", 32'(br_take), 32'h0);
    chk("reset.br_adr",  br_adr,       32'h0);
    idle_inputs();
    RST_N = 1'b1;

    // Directed vector table; first entry is the first capture after release.
    for (int i = 0; i < int'(NVEC); i++) begin
      v = tbl[i];
      drive(v);
      tick();
      nm = $sformatf("vec%0d", i);
      if (v.chk_d) chk({nm, ".data"}, wb_data, v.e_data);
      chk({nm, ".we"},   32'(wb_we),    32'(v.e_rw));
      chk({nm, ".reg"},  32'(wb_reg),   32'(v.dest));
      chk({nm, ".mode"}, 32'(wb_mode),  32'(v.mode));
      chk({nm, ".mis"},  32'(misalign), 32'(v.e_mis));
    end

    // Sticky flag holds through idle cycles.
    idle_inputs();
    for (int i = 0; i < 10; i++) begin
      tick();
      chk($sformatf("mis_hold%0d", i), 32'(misalign), 32'h1);
    end

    // Branch resolution is combinational.
    branch = 1; zero = 1; pc = 32'h40;
    #1;
    chk("br.take",  32'(br_take), 32'h1);
    chk("br.adr",   br_adr,       32'h40);
    zero = 0;
    #1;
    chk("br.nottaken", 32'(br_take), 32'h0);
    branch = 0; zero = 1;
    #1;
    chk("br.nobranch", 32'(br_take), 32'h0);
    tick();

    // Reset mid-stream alongside a store.
    idle_inputs();
    mem_write = 1; load_mode = 2'd0; alu = 32'h30; rt = 32'h55; reg_write = 1; dest = 5'd7;
    RST_N = 1'b0;
    tick();
    chk_all_zero("midrst");
    RST_N = 1'b1;
    idle_inputs();
    mem_read = 1; mem_to_reg = 1; reg_write = 1; alu = 32'h30; dest = 5'd3;
    tick();
    chk("midrst.lw30", wb_data, 32'h0);
    chk("midrst.we",   32'(wb_we), 32'h1);
    alu = 32'h10;
    tick();
    chk("midrst.lw10", wb_data, 32'h0);

    // Random traffic against the model, starting from cleared memory.
    for (int k = 0; k < 256; k++) mdl[k] = 32'h0;
    mdl_mis = 1'b0;
    for (int n = 0; n < 400; n++) begin
      v.rd   = 1'($urandom_range(0, 1));
      v.wr   = 1'($urandom_range(0, 2) == 0);
      v.rw   = 1'($urandom_range(0, 1));
      v.m2r  = v.rd;
      v.mode = 2'($urandom_range(0, 3));
      v.dest = 5'($urandom);
      v.addr = 32'($urandom_range(0, 63));
      if ($urandom_range(0, 7) == 0) v.addr = v.addr | ($urandom << 10);
      v.rt   = $urandom;
      rst    = ($urandom_range(0, 39) != 0);
      drive(v);
      branch = 1'($urandom_range(0, 1));
      zero   = 1'($urandom_range(0, 1));
      pc     = $urandom;
      RST_N  = rst;
      #1;
      chk("rnd.br_take", 32'(br_take), 32'(rst & branch & zero));
      chk("rnd.br_adr",  br_adr,       rst ? pc : 32'h0);

      widx  = (v.addr / 4) % 256;
      old_w = mdl[widx];
      mis   = (v.rd | v.wr) & m_misal(v.addr, v.mode);
      e_data = v.m2r ? m_load(old_w, v.addr, v.mode) : v.addr;
      if (rst) begin
        if (v.wr && !m_misal(v.addr, v.mode)) mdl[widx] = m_store(old_w, v.addr, v.mode, v.rt);
        if (mis) mdl_mis = 1'b1;
      end else begin
        for (int k = 0; k < 256; k++) mdl[k] = 32'h0;
        mdl_mis = 1'b0;
      end
      tick();
      if (!rst) begin
        chk_all_zero("rnd.rst");
      end else begin
        if (!(v.rd && (mis || v.wr))) chk("rnd.data", wb_data, e_data);
        chk("rnd.we",   32'(wb_we),
            32'(v.rw && !(v.rd && m_misal(v.addr, v.mode)) && !(v.rd && v.wr)));
        chk("rnd.reg",  32'(wb_reg),   32'(v.dest));
        chk("rnd.mode", 32'(wb_mode),  32'(v.mode));
        chk("rnd.mis",  32'(misalign), 32'(mdl_mis));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_wb_stage.md
MEM_WB_STAGE -- requirements
Module: mem_wb_stage

Interface
- REQ-001 The block SHALL use one clock and a synchronous, active-low reset: CLK and RST_N.
- REQ-002 The ports SHALL be as follows, one per line as: name, direction, width, meaning.
  - CLK  in  1  rising-edge clock.
  - RST_N  in  1  synchronous active-low reset, sampled on the CLK rising edge.
  - EX_MEM_zero_out  in  1  ALU zero flag.
  - EX_MEM_branch_out  in  1  branch instruction.
  - EX_MEM_RegWrite_out  in  1  writeback enable.
  - EX_MEM_MemWrite_out  in  1  store.
  - EX_MEM_MemRead_out  in  1  load.
  - EX_MEM_MemToReg_out  in  1  writeback select, 1 = memory data.
  - EX_MEM_load_mode_out  in  2  access size: 00 word, 01 half signed, 10 byte signed, 11 byte unsigned (a store with 11 is a byte store).
  - EX_MEM_IF_MEM_writebackDestination_out  in  5  destination register.
  - EX_MEM_aluResult_out  in  32  byte address or ALU result.
  - EX_MEM_rt_out  in  32  store data.
  - EX_MEM_pc_out  in  32  branch target.
  - MEM_IF_BR_NEXT_INS_ADR  out  32  branch target to IF.
  - MEM_IF_MEM_WRITE  out  1  PC-select to IF, 1 = take the branch.
  - delay_write_register  out  5  WB destination.
  - delay_write_data  out  32  WB data.
  - delay_in_RegWrite  out  1  WB enable.
  - delay_in_load_mode  out  2  WB access size, pass-through.
  - MISALIGN  out  1  sticky misaligned-access flag.
- REQ-003 The block SHALL have one parameter: DEPTH, default 256, data memory size in 32-bit words.

Function
- REQ-004 Branch resolution SHALL be combinational:
  - MEM_IF_MEM_WRITE = EX_MEM_branch_out & EX_MEM_zero_out.
  - MEM_IF_BR_NEXT_INS_ADR = EX_MEM_pc_out.
  - Both outputs SHALL be 0 while RST_N=0.
- REQ-005 The data memory SHALL be internal and big-endian.
  - Word index = aluResult[log2(DEPTH)+1:2]; upper address bits are ignored (wrap-around).
  - Byte offset 0 maps to bits [31:24]; halfword offset 0 maps to bits [31:16].
- REQ-006 Stores SHALL commit on the rising edge that ends the cycle in which MemWrite=1.
  - Only the addressed lanes change.
  - Lane data comes from rt[7:0] for bytes and rt[15:0] for halfwords.
- REQ-007 Loads SHALL read the array combinationally and be captured into the MEM/WB register on the same edge.
  - A load in cycle N+1 to an address stored in cycle N SHALL return the new data.
- REQ-008 Load extension by mode:
  - 00: the whole word.
  - 01: sign-extend the selected halfword.
  - 10: sign-extend the selected byte.
  - 11: zero-extend the selected byte.
- REQ-009 The MEM/WB register SHALL update on every rising edge with RST_N=1, giving one cycle of latency from EX/MEM inputs to delay_* outputs:
  - delay_write_register = dest.
  - delay_in_load_mode = load_mode.
  - delay_write_data = MemToReg ? extended load data : aluResult.
  - delay_in_RegWrite = RegWrite, except where forced to 0 by REQ-010 or REQ-011.
- REQ-010 Misaligned accesses:
  - A word access with addr[1:0]≠0, or a halfword access with addr[0]≠0, is misaligned.
  - A misaligned store SHALL NOT modify memory.
  - A misaligned load SHALL force delay_in_RegWrite=0.
  - Either case SHALL set MISALIGN=1, and MISALIGN SHALL hold until reset.
- REQ-011 MemRead=1 and MemWrite=1 in the same cycle:
  - The store is performed per REQ-006.
  - delay_in_RegWrite is forced to 0.
  - MISALIGN is unaffected.
- REQ-012 A write to register 0 SHALL be forwarded unchanged; suppressing it is the register file's responsibility.
- REQ-013 Control with MemRead=MemWrite=0 SHALL NOT access memory, and the aluResult path SHALL still be written back.

Reset
- REQ-014 On a rising edge with RST_N=0:
  - All delay_* outputs are 0.
  - MISALIGN is 0.
  - All DEPTH memory words are 0.
  - Any store presented that cycle is discarded.
- REQ-015 Reset mid-operation SHALL take priority over a simultaneous store or writeback capture.
- REQ-016 After reset is released, the first capture SHALL occur on the next rising edge.

Verification
- REQ-017 Word round trip: SW rt=0xDEADBEEF to addr 0x10; LW to 0x10 next cycle with MemToReg=1, dest=5 -> one cycle later delay_write_data=0xDEADBEEF, delay_write_register=5, delay_in_RegWrite=1.
- REQ-018 Sub-word: SB rt=0x80 to addr 0x13 over the word 0 -> LB at 0x13 returns 0xFFFFFF80, LBU returns 0x00000080, LW at 0x10 returns 0x00000080.
- REQ-019 Halfword: SH rt=0x1234ABCD to addr 0x22 -> LW at 0x20 returns 0x0000ABCD; LH at 0x22 returns 0xFFFFABCD.
- REQ-020 Misaligned: LW at 0x11 with RegWrite=1 -> delay_in_RegWrite=0 and MISALIGN=1, held through 10 further cycles; SW at 0x12 leaves word 0x10 unchanged.
- REQ-021 Branch: branch=1, zero=1, pc=0x40 -> MEM_IF_MEM_WRITE=1 and MEM_IF_BR_NEXT_INS_ADR=0x40 in the same cycle; with zero=0 -> MEM_IF_MEM_WRITE=0.
- REQ-022 Reset mid-stream: assert RST_N=0 in the same cycle as SW 0x55 to 0x30 -> all outputs 0, MISALIGN=0; after release, LW at 0x30 returns 0.
